// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ readout buffer.
// Contents: slot count, readout length limit, RAM row address width
// and the encodings of the write-side state machine.
package daq_pkg;

    localparam int unsigned DAQ_NBUF_LOG2 = 6;
    localparam logic [10:0] DAQ_MAXLEN    = 11'd2047;
    localparam int unsigned DAQ_ROW_AW    = DAQ_NBUF_LOG2 + 10;

    // WWait must stay at zero: the status word reads back all-zero after reset.
    typedef enum logic [1:0] {
        WWait   = 2'd0,
        WFill   = 2'd1,
        WCommit = 2'd2
    } wstate_e;

endpackage

// File: rtl/daq_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port and one read port.
// The read path has two stages: the address is registered, then the data is registered.
// Ports:
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write row address
//   wdata_i - write data
//   raddr_i - read row address
//   rdata_o - read data, valid two cycles after raddr_i
module daq_sdp_ram
    import daq_pkg::*;
#(
    parameter int unsigned AddrWidth = DAQ_ROW_AW,
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [AddrWidth-1:0] raddr_q;
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        raddr_q <= raddr_i;
        rdata_q <= mem_q[raddr_q];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/daq_buffer_manager.sv
// Multi-slot readout store that feeds the DMA stage.
// Each readout is a stream of 32-bit words. The words are packed in pairs into 64-bit rows
// of the slot at wr_buf_id, and the readout length is recorded when the readout is committed.
// Committed readouts are released in FIFO order by done_with_buffer_i.
// Ports:
//   clk_i, reset_i (synchronous, active high), enable_i (low acts as a synchronous clear)
//   wr_data_i / wr_valid_i / wr_last_i / wr_ready_o - readout stream input
//   nreadouts_available_o, r_buf_id_o               - committed count and oldest slot id
//   pick_buf_id_i, r_ptr_i                          - random-access read address
//   buf_len_o, data_from_buffer_o                   - read results, two cycles after the address
//   done_with_buffer_i                              - releases the oldest readout
//   status_o                                        - {trunc, rel_err, full, 0, wstate, 0000, count}
module daq_buffer_manager
    import daq_pkg::*;
#(
    parameter int unsigned NBUF_LOG2 = DAQ_NBUF_LOG2,
    parameter logic [10:0] MAXLEN    = DAQ_MAXLEN
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [31:0]          wr_data_i,
    input  logic                 wr_valid_i,
    input  logic                 wr_last_i,
    output logic                 wr_ready_o,
    output logic [NBUF_LOG2-1:0] nreadouts_available_o,
    output logic [NBUF_LOG2-1:0] r_buf_id_o,
    input  logic [NBUF_LOG2-1:0] pick_buf_id_i,
    input  logic [10:0]          r_ptr_i,
    output logic [10:0]          buf_len_o,
    output logic [63:0]          data_from_buffer_o,
    input  logic                 done_with_buffer_i,
    output logic [15:0]          status_o
);

    localparam int unsigned NBuf  = 1 << NBUF_LOG2;
    localparam int unsigned RowAw = NBUF_LOG2 + 10;
    localparam logic [NBUF_LOG2-1:0] MaxOcc = NBUF_LOG2'(NBuf - 1);
    localparam logic [NBUF_LOG2-1:0] IdOne  = NBUF_LOG2'(1);

    logic clear;
    assign clear = reset_i || !enable_i;

    wstate_e              state_q, state_d;
    logic [NBUF_LOG2-1:0] wr_buf_id_q, wr_buf_id_d;
    logic [NBUF_LOG2-1:0] rd_buf_id_q, rd_buf_id_d;
    logic [NBUF_LOG2-1:0] count_q, count_d;
    logic [10:0]          widx_q, widx_d;    // words stored so far, saturates at MAXLEN
    logic [31:0]          pend_q, pend_d;    // even word waiting for its odd partner
    logic                 trunc_q, trunc_d;
    logic                 rel_err_q, rel_err_d;

    logic             ram_we;
    logic [RowAw-1:0] ram_waddr;
    logic [63:0]      ram_wdata;
    logic             len_we;
    logic             commit;
    logic             release_ok;
    logic [NBUF_LOG2:0] occupancy;
    logic             full;

    // The slot being filled or committed counts toward occupancy.
    assign occupancy = {1'b0, count_q} + {{NBUF_LOG2{1'b0}}, (state_q != WWait)};
    assign full      = (occupancy == {1'b0, MaxOcc});

    always_comb begin
        state_d     = state_q;
        wr_buf_id_d = wr_buf_id_q;
        rd_buf_id_d = rd_buf_id_q;
        count_d     = count_q;
        widx_d      = widx_q;
        pend_d      = pend_q;
        trunc_d     = trunc_q;
        rel_err_d   = rel_err_q;
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = '0;
        len_we      = 1'b0;
        commit      = 1'b0;
        wr_ready_o  = 1'b0;

        unique case (state_q)
            WWait: begin
                widx_d = '0;
                if (count_q < MaxOcc) begin
                    state_d = WFill;
                end
            end
            WFill: begin
                wr_ready_o = 1'b1;
                if (wr_valid_i) begin
                    if (widx_q < MAXLEN) begin
                        widx_d = widx_q + 11'd1;
                        if (!widx_q[0]) begin
                            pend_d = wr_data_i;
                        end else begin
                            ram_we    = 1'b1;
                            ram_waddr = {wr_buf_id_q, widx_q[10:1]};
                            ram_wdata = {wr_data_i, pend_q};
                        end
                    end else begin
                        // Overlong readout: accept the word and drop it.
                        trunc_d = 1'b1;
                    end
                    if (wr_last_i) begin
                        state_d = WCommit;
                    end
                end
            end
            WCommit: begin
                commit = 1'b1;
                // An odd length leaves one word pending, so it is flushed with a zero upper half.
                if (widx_q[0]) begin
                    ram_we    = 1'b1;
                    ram_waddr = {wr_buf_id_q, widx_q[10:1]};
                    ram_wdata = {32'h0, pend_q};
                end
                len_we      = 1'b1;
                wr_buf_id_d = wr_buf_id_q + IdOne;
                state_d     = WWait;
            end
            default: state_d = WWait;
        endcase

        release_ok = done_with_buffer_i && (count_q != '0);
        if (done_with_buffer_i && (count_q == '0)) begin
            rel_err_d = 1'b1;
        end
        if (release_ok) begin
            rd_buf_id_d = rd_buf_id_q + IdOne;
        end

        unique case ({commit, release_ok})
            2'b10:   count_d = count_q + IdOne;
            2'b01:   count_d = count_q - IdOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            state_q     <= WWait;
            wr_buf_id_q <= '0;
            rd_buf_id_q <= '0;
            count_q     <= '0;
            widx_q      <= '0;
            pend_q      <= '0;
            trunc_q     <= 1'b0;
            rel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_buf_id_q <= wr_buf_id_d;
            rd_buf_id_q <= rd_buf_id_d;
            count_q     <= count_d;
            widx_q      <= widx_d;
            pend_q      <= pend_d;
            trunc_q     <= trunc_d;
            rel_err_q   <= rel_err_d;
        end
    end

    // The length table uses the same two-stage read as the data RAM, so both outputs stay aligned.
    logic [10:0]          len_mem_q [NBuf];
    logic [NBUF_LOG2-1:0] len_raddr_q;
    logic [10:0]          buf_len_q;

    always_ff @(posedge clk_i) begin
        if (len_we) begin
            len_mem_q[wr_buf_id_q] <= widx_q;
        end
        len_raddr_q <= pick_buf_id_i;
        buf_len_q   <= len_mem_q[len_raddr_q];
    end

    daq_sdp_ram #(
        .AddrWidth (RowAw),
        .DataWidth (64)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i ({pick_buf_id_i, r_ptr_i[10:1]}),
        .rdata_o (data_from_buffer_o)
    );

    // r_ptr_i[0] selects the half of a row, which the consumer picks itself.
    logic unused_ptr_lsb;
    assign unused_ptr_lsb = r_ptr_i[0];

    assign buf_len_o             = buf_len_q;
    assign nreadouts_available_o = count_q;
    assign r_buf_id_o            = rd_buf_id_q;
    assign status_o = {trunc_q, rel_err_q, full, 1'b0, state_q, 4'h0, count_q};

endmodule

// File: tb/tb_daq_buffer_manager.sv
module tb_daq_buffer_manager;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_last;
    logic        wr_ready;
    logic [5:0]  nreadouts;
    logic [5:0]  r_buf_id;
    logic [5:0]  pick;
    logic [10:0] r_ptr;
    logic [10:0] buf_len;
    logic [63:0] dfb;
    logic        done;
    logic [15:0] status;

    always #5 clk = ~clk;

    daq_buffer_manager dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .enable_i              (enable),
        .wr_data_i             (wr_data),
        .wr_valid_i            (wr_valid),
        .wr_last_i             (wr_last),
        .wr_ready_o            (wr_ready),
        .nreadouts_available_o (nreadouts),
        .r_buf_id_o            (r_buf_id),
        .pick_buf_id_i         (pick),
        .r_ptr_i               (r_ptr),
        .buf_len_o             (buf_len),
        .data_from_buffer_o    (dfb),
        .done_with_buffer_i    (done),
        .status_o              (status)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Reference model of what has been written.
    logic [31:0] mw [64][2048];
    logic [10:0] mlen [64];
    logic [5:0]  exp_wr_id;
    logic [5:0]  exp_rd_id;
    int          exp_count;
    logic        exp_rel_err;

    typedef struct {
        int          slot;
        int          row;
        logic [10:0] len;
        logic [63:0] data;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    logic rd_issue = 1'b0;
    logic rd_v1 = 1'b0;
    logic rd_v2 = 1'b0;

    always @(posedge clk) begin
        rd_v1 <= rd_issue;
        rd_v2 <= rd_v1;
    end

    always @(negedge clk) begin
        if (rd_v2) begin
            check_eq("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                rd_exp_t e;
                e = sb_q.pop_front();
                check_eq($sformatf("len s%0d r%0d", e.slot, e.row), 64'(buf_len), 64'(e.len));
                check_eq($sformatf("data s%0d r%0d", e.slot, e.row), dfb, e.data);
            end
        end
    end

    task automatic read_row(input int slot, input int row);
        rd_exp_t e;
        e.slot = slot;
        e.row  = row;
        e.len  = mlen[slot];
        e.data[31:0]  = mw[slot][2*row];
        e.data[63:32] = (2*row + 1 < int'(mlen[slot])) ? mw[slot][2*row+1] : 32'h0;
        sb_q.push_back(e);
        pick     = 6'(slot);
        r_ptr    = 11'(2*row + (row % 2));
        rd_issue = 1'b1;
        @(posedge clk); #1;
        rd_issue = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // stop_after >= 0 abandons the readout after that many words, without committing it.
    task automatic send_readout(input int n, input bit gaps, input logic [31:0] base,
                                input int stop_after);
        bit rdy;
        int budget;
        for (int i = 0; i < n; i++) begin
            if (i == stop_after) begin
                wr_valid = 1'b0;
                wr_last  = 1'b0;
                return;
            end
            if (gaps && i > 0) begin
                wr_valid = 1'b0;
                @(posedge clk); #1;
            end
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            wr_last  = (i == n - 1);
            budget   = 0;
            do begin
                @(negedge clk);
                rdy = wr_ready;
                @(posedge clk); #1;
                budget++;
            end while (!rdy && budget < 500);
            if (!rdy) begin
                check_eq("wr_ready_wait", 64'(rdy), 64'd1);
                wr_valid = 1'b0;
                wr_last  = 1'b0;
                return;
            end
            if (i < 2047) mw[exp_wr_id][i] = wr_data;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        mlen[exp_wr_id] = (n > 2047) ? 11'd2047 : 11'(n);
        exp_wr_id++;
        exp_count++;
    endtask

    task automatic release_buf();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        if (exp_count > 0) begin
            exp_count--;
            exp_rd_id++;
        end else begin
            exp_rel_err = 1'b1;
        end
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_navail"}, 64'(nreadouts), 64'(exp_count));
        check_eq({tag, "_rbufid"}, 64'(r_buf_id), 64'(exp_rd_id));
    endtask

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        done     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_wr_ready"}, 64'(wr_ready), 64'd0);
        check_eq({tag, "_navail"}, 64'(nreadouts), 64'd0);
        check_eq({tag, "_rbufid"}, 64'(r_buf_id), 64'd0);
        check_eq({tag, "_status"}, 64'(status), 64'd0);
        @(posedge clk); #1;
        reset       = 1'b0;
        exp_wr_id   = '0;
        exp_rd_id   = '0;
        exp_count   = 0;
        exp_rel_err = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_status;
        reset    = 1'b1;
        enable   = 1'b1;
        wr_data  = '0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        pick     = '0;
        r_ptr    = '0;
        done     = 1'b0;
        wait_cycles(3);
        do_reset("rst");

        // Single 5-word readout.
        send_readout(5, 1'b0, 32'd1, -1);
        @(negedge clk);
        check_eq("t1_navail_in_commit", 64'(nreadouts), 64'd0);
        check_eq("t1_ready_in_commit", 64'(wr_ready), 64'd0);
        @(negedge clk);
        check_counts("t1");
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) read_row(0, r);
        drain();

        // 4 words with wr_valid toggling.
        send_readout(4, 1'b1, 32'd1, -1);
        wait_cycles(2);
        check_counts("t2");
        for (int r = 0; r < 2; r++) read_row(1, r);
        drain();

        // Fill every slot, then release one.
        for (int k = 0; k < 61; k++) send_readout(2, 1'b0, 32'h100 * 32'(k), -1);
        wait_cycles(3);
        check_counts("t3_full");
        exp_status = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 6'd63};
        check_eq("t3_status_full", 64'(status), 64'(exp_status));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("t3_stalled", 64'(wr_ready), 64'd0);
        end
        @(posedge clk); #1;
        release_buf();
        @(negedge clk);
        check_counts("t3_release");
        @(posedge clk); #1;
        send_readout(3, 1'b0, 32'hA0, -1);
        wait_cycles(2);
        check_counts("t3_resume");
        read_row(63, 0);
        read_row(63, 1);
        read_row(2, 0);
        drain();
        do_reset("rst2");

        // Reset in the middle of a readout.
        send_readout(20, 1'b0, 32'hB00, 10);
        do_reset("midrst");
        send_readout(7, 1'b0, 32'hC00, -1);
        wait_cycles(2);
        check_counts("t6");
        for (int r = 0; r < 4; r++) read_row(0, r);
        drain();

        // Overlong readout, then a normal one in the next slot.
        send_readout(2100, 1'b0, 32'h10000, -1);
        wait_cycles(2);
        check_eq("t4_trunc", 64'(status[15]), 64'd1);
        read_row(1, 0);
        read_row(1, 511);
        read_row(1, 1023);
        send_readout(3, 1'b0, 32'h7000_0000, -1);
        wait_cycles(2);
        check_counts("t4_next");
        read_row(2, 0);
        read_row(2, 1);
        drain();

        // Commit and release in the same cycle at count 3.
        send_readout(2, 1'b0, 32'hD00, -1);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        exp_count--;
        exp_rd_id++;
        @(negedge clk);
        check_counts("t5_same_cycle");
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) release_buf();
        @(negedge clk);
        check_counts("t5_drained");
        check_eq("t5_relerr_clear", 64'(status[14]), 64'(exp_rel_err));
        @(posedge clk); #1;
        release_buf();
        @(negedge clk);
        check_counts("t5_release_at_zero");
        check_eq("t5_relerr_set", 64'(status[14]), 64'(exp_rel_err));
        check_eq("t5_trunc_kept", 64'(status[15]), 64'd1);
        @(posedge clk); #1;
        send_readout(2, 1'b0, 32'hE00, -1);
        wait_cycles(2);
        check_counts("t5_next");
        read_row(4, 0);
        read_row(3, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
